multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum wait cycles for memory before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode_i  input  6  instruction[31:26] from instruction register, valid from DECODE onward.
REQ-005 zero_i  input  1  ALU zero flag, valid in BRANCH.
REQ-006 mem_ready_i  input  1  memory completion strobe for current request.
REQ-007 mem_read_o / mem_write_o  output  1 each  memory request; held until mem_ready_i or timeout.
REQ-008 i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 ir_write_o, pc_write_o, reg_write_o  output  1 each  register enables.
REQ-010 reg_dst_o, mem_to_reg_o, alu_src_a_o  output  1 each  datapath mux selects (0 = rt / ALU / PC; 1 = rd / memory data / rs).
REQ-011 alu_src_b_o  output  2  00 = rt, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
REQ-012 alu_op_o  output  3  111 R-type funct, 110 LUI, 101 OR, 100 ADD, 011 SUB.
REQ-013 pc_source_o  output  2  00 = ALU, 01 = ALU result register, 10 = jump target.
REQ-014 illegal_op_o, mem_timeout_o  output  1 each  single-cycle error pulses.
REQ-015 state_o  output  4  current state encoding for debug.

Function
REQ-016 Moore FSM states (encoding): FETCH 0, DECODE 1, EXEC 2, MEM_ADDR 3, MEM_RD 4, MEM_WR 5, WB_ALU 6, WB_MEM 7, BRANCH 8, JUMP 9; others unreachable, decode to FETCH.
REQ-017 Opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
REQ-018 All outputs not listed for a state are 0; alu_op_o defaults to 100.
REQ-019 FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=100; on mem_ready_i: ir_write_o=1, pc_write_o=1, pc_source_o=00, next DECODE; else stay.
REQ-020 DECODE: alu_src_b_o=11, alu_op_o=100 (branch target); next by opcode: R/ADDI/ORI/LUI -> EXEC, LW/SW -> MEM_ADDR, BEQ/BNE -> BRANCH, J -> JUMP, any other -> FETCH with illegal_op_o=1 for that cycle.
REQ-021 EXEC: alu_src_a_o=1; R: alu_src_b_o=00, alu_op_o=111; ADDI/ORI/LUI: alu_src_b_o=10, alu_op_o 100/101/110; next WB_ALU.
REQ-022 WB_ALU: reg_write_o=1, mem_to_reg_o=0, reg_dst_o=1 for R else 0, ALU inputs held as in EXEC; next FETCH.
REQ-023 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=100; next MEM_RD (LW) or MEM_WR (SW).
REQ-024 MEM_RD / MEM_WR: i_or_d_o=1, mem_read_o / mem_write_o=1; on mem_ready_i next WB_MEM (LW) or FETCH (SW); else stay.
REQ-025 WB_MEM: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0; next FETCH.
REQ-026 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=011, pc_source_o=01; pc_write_o=zero_i for BEQ, ~zero_i for BNE; next FETCH.
REQ-027 JUMP: pc_source_o=10, pc_write_o=1; next FETCH.
REQ-028 Latency (zero wait): J 3, BEQ/BNE 3, R/I-ALU 4, SW 4, LW 5 cycles including FETCH.
REQ-029 8-bit wait counter clears on every state entry, increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready_i=0; saturates at 255.
REQ-030 Wait counter reaching MAX_WAIT without mem_ready_i: pulse mem_timeout_o one cycle, drop request, next FETCH, no register/PC write; a FETCH timeout retries the same PC.
REQ-031 mem_ready_i and timeout in the same cycle: mem_ready_i wins, no timeout pulse.
REQ-032 mem_ready_i outside FETCH/MEM_RD/MEM_WR is ignored.
REQ-033 Opcode is sampled only in states after DECODE; opcode_i changes in FETCH have no effect.

Reset
REQ-034 reset=1 at a clock edge forces FETCH, wait counter 0, all outputs to REQ-018 defaults plus FETCH Moore values the next cycle, overriding any in-progress memory access (aborted, no writes).
REQ-035 Reset takes precedence over mem_ready_i and timeout in the same cycle.

Verification
REQ-036 Reset held 2 cycles, released -> state_o=0, mem_read_o=1, pc_write_o=0 until mem_ready_i.
REQ-037 R-type (opcode 0x00), mem_ready_i high in FETCH -> states 0,1,2,6,0; reg_write_o=1 and reg_dst_o=1 only in cycle 4.
REQ-038 LW (0x23), 3 wait cycles in MEM_RD -> states 0,1,3,4,4,4,4,7,0; mem_to_reg_o=1 in WB_MEM.
REQ-039 BEQ zero_i=1 -> pc_write_o=1 in BRANCH; BNE zero_i=1 -> pc_write_o=0; both return to FETCH.
REQ-040 Opcode 0x3F -> illegal_op_o one-cycle pulse in DECODE, then FETCH, no writes; MAX_WAIT=4 with mem_ready_i stuck 0 in FETCH -> mem_timeout_o pulse after 4 wait cycles.
REQ-041 reset asserted during MEM_WR -> mem_write_o=0 next cycle, state FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with a bounded wait on memory completion.
module multicycle_control #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_ALU   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  state_t     state, state_d;
  logic [7:0] wait_cnt, wait_cnt_d;
  logic       wait_state;
  logic       timeout;

  // Memory request: a read/write is held each cycle until mem_ready_i is seen
  // (transfer completes that cycle) or the wait budget runs out (request dropped).
  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout    = wait_state && !mem_ready_i && (wait_cnt == MAX_CNT);
  assign state_o    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state)
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_R, OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = S_BRANCH;
          OP_J:                          state_d = S_JUMP;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_EXEC:     state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready_i ? S_WB_MEM : (timeout ? S_FETCH : S_MEM_RD);
      S_MEM_WR:   state_d = (mem_ready_i || timeout) ? S_FETCH : S_MEM_WR;
      default:    state_d = S_FETCH;
    endcase

    // A timeout in FETCH re-enters FETCH, so it must also restart the count.
    wait_cnt_d = wait_cnt;
    if (state_d != state || timeout)
      wait_cnt_d = 8'd0;
    else if (wait_state && !mem_ready_i && wait_cnt != 8'hFF)
      wait_cnt_d = wait_cnt + 8'd1;
  end

  always_comb begin
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    i_or_d_o      = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 3'b100;
    pc_source_o   = 2'b00;
    illegal_op_o  = 1'b0;
    mem_timeout_o = timeout;
    case (state)
      S_FETCH: begin
        mem_read_o  = !timeout;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
          OP_ORI, OP_LUI, OP_LW, OP_SW: illegal_op_o = 1'b0;
          default:                      illegal_op_o = 1'b1;
        endcase
      end
      S_EXEC, S_WB_ALU: begin
        alu_src_a_o = 1'b1;
        reg_write_o = (state == S_WB_ALU);
        reg_dst_o   = (state == S_WB_ALU) && (opcode_i == OP_R);
        case (opcode_i)
          OP_R: begin
            alu_src_b_o = 2'b00;
            alu_op_o    = 3'b111;
          end
          OP_ORI: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b101;
          end
          OP_LUI: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b110;
          end
          default: alu_src_b_o = 2'b10;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        i_or_d_o   = 1'b1;
        mem_read_o = !timeout;
      end
      S_MEM_WR: begin
        i_or_d_o    = 1'b1;
        mem_write_o = !timeout;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b00;
        alu_op_o    = 3'b011;
        pc_source_o = 2'b01;
        pc_write_o  = (opcode_i == OP_BNE) ? !zero_i : zero_i;
      end
      S_JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
